// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and counter-width helper for seq_divider
package div_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake and operand/result bus of the divider
interface seq_divider_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div_sub_stage.sv
// div_sub_stage: ripple trial subtractor a - b as a + ~b + 1 over a full-adder chain
module div_sub_stage
  import div_pkg::*;
#(
  parameter int N = DEF_WIDTH + 1
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         neg_o
);
  logic [N:0] c;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign diff_o[i] = a_i[i] ^ ~b_i[i] ^ c[i];
    assign c[i+1]    = (a_i[i] & ~b_i[i]) | (c[i] & (a_i[i] ^ ~b_i[i]));
  end
  // No carry out of the chain means a borrow occurred: the trial result is negative.
  assign neg_o = ~c[N];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per clock (optional macro SEQ_DIVIDER_DBZ_EN)
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);
  localparam int CW = clog2(WIDTH);
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] q_q, div_q, quo_q, rem_q, q_d;
  logic [WIDTH:0]   r_q, r_sh, diff, r_d;
  logic             neg, busy_q, done_q, dbz_q, dbz_out_q, dbz_acc, accept;
  assign r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  div_sub_stage #(.N(WIDTH + 1)) u_sub (
    .a_i    (r_sh),
    .b_i    ({1'b0, div_q}),
    .diff_o (diff),
    .neg_o  (neg)
  );
`ifdef SEQ_DIVIDER_DBZ_EN
  assign dbz_acc = (bus.divisor == '0);
`else
  assign dbz_acc = 1'b0;
`endif
  assign accept = bus.start && (state_q != S_RUN);
  // One restoring step: keep the difference when non-negative, otherwise restore.
  always_comb begin
    r_d = neg ? r_sh : diff;
    q_d = {q_q[WIDTH-2:0], ~neg};
  end
  // FSM with counter, Q/R shift registers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      div_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      dbz_out_q <= 1'b0;
    end else if (accept) begin
      state_q <= S_RUN;
      cnt_q   <= CW'(WIDTH - 1);
      q_q     <= bus.dividend;
      r_q     <= '0;
      div_q   <= bus.divisor;
      dbz_q   <= dbz_acc;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (state_q == S_RUN) begin
      if (dbz_q) begin
        quo_q     <= '1;
        rem_q     <= q_q;
        dbz_out_q <= 1'b1;
        done_q    <= 1'b1;
        state_q   <= S_DONE;
      end else begin
        q_q <= q_d;
        r_q <= r_d;
        if (cnt_q == '0) begin
          quo_q     <= q_d;
          rem_q     <= r_d[WIDTH-1:0];
          dbz_out_q <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= S_DONE;
        end else begin
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end else begin
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      state_q <= S_IDLE;
    end
  end
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_out_q;
endmodule
